// File: rtl/dma_burst_master_if.sv
// AXI4 master-side bus bundle for dma_burst_master: AR/R/AW/W/B channels, 32-bit data.
interface dma_burst_master_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/dma_burst_master.sv
// Single-burst AXI4 DMA engine: a read burst fills the local buffer, a write burst drains it,
// so read-then-write forms a memory-to-memory copy.
module dma_burst_master #(
  parameter int BURST_LEN = 16,
  parameter int ADDR_W    = 32
) (
  input  logic               m_axi_aclk,
  input  logic               axi_resetnn,
  input  logic               read_active,
  input  logic [31:0]        read_address,
  output logic               read_idle,
  input  logic               write_active,
  input  logic [31:0]        write_address,
  output logic               write_idle,
  output logic [3:0]         rw_resp,
  dma_burst_master_if.master m_axi
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);
  localparam int         IDX_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } state_t;

  state_t            state_reg;
  logic [7:0]        cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              arvalid_reg;
  logic              rready_reg;
  logic              awvalid_reg;
  logic              wvalid_reg;
  logic              wlast_reg;
  logic              bready_reg;
  logic              read_idle_reg;
  logic              write_idle_reg;
  logic [1:0]        rd_resp_reg;
  logic [1:0]        wr_resp_reg;
  logic [1:0]        rd_status_reg;
  logic [31:0]       wdata_reg;

  logic [31:0]       buffer [0:BURST_LEN-1];

  logic [7:0]        cnt_inc;
  logic              r_hs;
  logic              aw_hs;
  logic              w_hs;
  logic              r_final;
  logic [1:0]        beat_status;
  logic [1:0]        rd_status_next;
  logic              buf_re;
  logic [IDX_W-1:0]  buf_raddr;

  assign cnt_inc = cnt_reg + 8'd1;
  assign r_hs    = rready_reg & m_axi.rvalid;
  assign aw_hs   = awvalid_reg & m_axi.awready;
  assign w_hs    = wvalid_reg & m_axi.wready;
  assign r_final = (cnt_reg == LAST_BEAT);

  // A beat is in error if the slave says so, or if rlast disagrees with our own beat count.
  always_comb begin
    beat_status = 2'b00;
    if (m_axi.rresp != 2'b00) begin
      beat_status = m_axi.rresp;
    end else if (m_axi.rlast != r_final) begin
      beat_status = 2'b10;
    end
  end

  assign rd_status_next = (rd_status_reg != 2'b00) ? rd_status_reg : beat_status;

  // wdata is the registered read port: prefetch beat 0 on AW handshake, then beat cnt+1 per accept.
  assign buf_re    = aw_hs | (w_hs & ~wlast_reg);
  assign buf_raddr = aw_hs ? '0 : cnt_inc[IDX_W-1:0];

  always_ff @(posedge m_axi_aclk) begin
    if (r_hs) begin
      buffer[cnt_reg[IDX_W-1:0]] <= m_axi.rdata;
    end
    if (buf_re) begin
      wdata_reg <= buffer[buf_raddr];
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!axi_resetnn) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      addr_reg       <= '0;
      arvalid_reg    <= 1'b0;
      rready_reg     <= 1'b0;
      awvalid_reg    <= 1'b0;
      wvalid_reg     <= 1'b0;
      wlast_reg      <= 1'b0;
      bready_reg     <= 1'b0;
      read_idle_reg  <= 1'b1;
      write_idle_reg <= 1'b1;
      rd_resp_reg    <= 2'b00;
      wr_resp_reg    <= 2'b00;
      rd_status_reg  <= 2'b00;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (read_active) begin
            addr_reg      <= ADDR_W'(read_address & 32'hFFFF_FFFC);
            arvalid_reg   <= 1'b1;
            read_idle_reg <= 1'b0;
            state_reg     <= RD_ADDR;
          end else if (write_active) begin
            addr_reg       <= ADDR_W'(write_address & 32'hFFFF_FFFC);
            awvalid_reg    <= 1'b1;
            write_idle_reg <= 1'b0;
            state_reg      <= WR_ADDR;
          end
        end

        RD_ADDR: begin
          if (m_axi.arready) begin
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b1;
            cnt_reg       <= '0;
            rd_status_reg <= 2'b00;
            state_reg     <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (r_hs) begin
            rd_status_reg <= rd_status_next;
            if (r_final) begin
              cnt_reg       <= '0;
              rready_reg    <= 1'b0;
              read_idle_reg <= 1'b1;
              rd_resp_reg   <= rd_status_next;
              state_reg     <= IDLE;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
        end

        WR_ADDR: begin
          if (m_axi.awready) begin
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b1;
            wlast_reg   <= (LAST_BEAT == 8'd0);
            cnt_reg     <= '0;
            state_reg   <= WR_DATA;
          end
        end

        WR_DATA: begin
          if (w_hs) begin
            if (wlast_reg) begin
              wvalid_reg <= 1'b0;
              wlast_reg  <= 1'b0;
              bready_reg <= 1'b1;
              cnt_reg    <= '0;
              state_reg  <= WR_RESP;
            end else begin
              cnt_reg   <= cnt_inc;
              wlast_reg <= (cnt_inc == LAST_BEAT);
            end
          end
        end

        WR_RESP: begin
          if (m_axi.bvalid) begin
            bready_reg     <= 1'b0;
            wr_resp_reg    <= m_axi.bresp;
            write_idle_reg <= 1'b1;
            state_reg      <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign read_idle  = read_idle_reg;
  assign write_idle = write_idle_reg;
  assign rw_resp    = {rd_resp_reg, wr_resp_reg};

  // The engine runs one direction at a time, so AR and AW share the latched base address.
  assign m_axi.araddr  = addr_reg;
  assign m_axi.arlen   = LAST_BEAT;
  assign m_axi.arsize  = 3'b010;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arvalid = arvalid_reg;
  assign m_axi.rready  = rready_reg;

  assign m_axi.awaddr  = addr_reg;
  assign m_axi.awlen   = LAST_BEAT;
  assign m_axi.awsize  = 3'b010;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awvalid = awvalid_reg;

  assign m_axi.wdata   = wdata_reg;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wlast   = wlast_reg;
  assign m_axi.wvalid  = wvalid_reg;
  assign m_axi.bready  = bready_reg;

endmodule

// File: tb/tb_dma_burst_master.sv
// Bench for dma_burst_master: table of directed read/write pairs, randomized stalled bursts
// against a transaction-level model, and a mid-burst reset sequence.
module tb_dma_burst_master;

  localparam int BL = 16;

  logic        clk;
  logic        axi_resetnn;
  logic        read_active;
  logic [31:0] read_address;
  logic        read_idle;
  logic        write_active;
  logic [31:0] write_address;
  logic        write_idle;
  logic [3:0]  rw_resp;

  dma_burst_master_if #(.ADDR_W(32)) m_axi ();

  dma_burst_master #(
    .BURST_LEN (BL),
    .ADDR_W    (32)
  ) dut (
    .m_axi_aclk    (clk),
    .axi_resetnn   (axi_resetnn),
    .read_active   (read_active),
    .read_address  (read_address),
    .read_idle     (read_idle),
    .write_active  (write_active),
    .write_address (write_address),
    .write_idle    (write_idle),
    .rw_resp       (rw_resp),
    .m_axi         (m_axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  // Slave-side beat plan for the next read burst, and the transaction-level model state.
  logic [31:0] beat_data [BL];
  logic [1:0]  beat_resp [BL];
  logic        beat_last [BL];
  logic [31:0] model_buf [BL];
  logic [1:0]  model_rd;
  logic [1:0]  model_wr;

  typedef struct {
    logic [31:0] rd_addr;
    logic [31:0] exp_araddr;
    bit          both;
    bit          noise;
    int          err_beat;
    logic [1:0]  err_val;
    int          last_beat;
    logic [31:0] data_base;
    logic [1:0]  exp_rd;
    bit          wr_en;
    logic [31:0] wr_addr;
    logic [31:0] exp_awaddr;
    logic [1:0]  bresp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc_cnt++;
  endtask

  // Read status from the protocol rules: the first beat with a non-OKAY rresp, or with rlast
  // disagreeing with "this is beat BL-1", decides the burst status.
  function automatic logic [1:0] model_status();
    for (int i = 0; i < BL; i++) begin
      if (beat_resp[i] != 2'b00) return beat_resp[i];
      if (beat_last[i] != (i == BL - 1)) return 2'b10;
    end
    return 2'b00;
  endfunction

  task automatic run_read(input logic [31:0] addr, input logic [31:0] exp_araddr,
                          input bit both, input bit noise, input int max_stall,
                          input logic [1:0] exp_rd, input int exp_lat);
    int st;
    cyc_cnt       = 0;
    read_address  = addr;
    read_active   = 1'b1;
    write_address = 32'h0000_6000;
    write_active  = both;
    step();
    read_active  = 1'b0;
    write_active = 1'b0;
    check("rd_idle_low", read_idle, 1'b0);
    check("arvalid", m_axi.arvalid, 1'b1);
    check("araddr", m_axi.araddr, exp_araddr);
    check("arlen", m_axi.arlen, 8'(BL - 1));
    check("arsize", m_axi.arsize, 3'b010);
    check("arburst", m_axi.arburst, 2'b01);
    check("ar_no_aw", m_axi.awvalid, 1'b0);
    st = $urandom_range(0, max_stall);
    for (int s = 0; s < st; s++) begin
      step();
      check("arvalid_hold", m_axi.arvalid, 1'b1);
      check("araddr_hold", m_axi.araddr, exp_araddr);
    end
    m_axi.arready = 1'b1;
    step();
    m_axi.arready = 1'b0;
    check("arvalid_drop", m_axi.arvalid, 1'b0);
    for (int i = 0; i < BL; i++) begin
      write_active = noise && (i < BL - 1);
      st = $urandom_range(0, max_stall);
      for (int s = 0; s < st; s++) begin
        m_axi.rvalid = 1'b0;
        m_axi.rdata  = 32'hDEAD_BEEF;
        step();
        check("rready_hold", m_axi.rready, 1'b1);
      end
      check("rready", m_axi.rready, 1'b1);
      check("rd_no_aw", m_axi.awvalid, 1'b0);
      m_axi.rvalid = 1'b1;
      m_axi.rdata  = beat_data[i];
      m_axi.rresp  = beat_resp[i];
      m_axi.rlast  = beat_last[i];
      step();
    end
    m_axi.rvalid = 1'b0;
    m_axi.rlast  = 1'b0;
    m_axi.rresp  = 2'b00;
    write_active = 1'b0;
    check("rd_idle_done", read_idle, 1'b1);
    check("rready_done", m_axi.rready, 1'b0);
    check("rw_resp_rd", rw_resp, {exp_rd, model_wr});
    if (exp_lat >= 0) check("rd_latency", cyc_cnt, exp_lat);
    model_rd = exp_rd;
    for (int i = 0; i < BL; i++) model_buf[i] = beat_data[i];
    $display("read  araddr=0x%08h status=%02b cycles=%0d", exp_araddr, exp_rd, cyc_cnt);
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [31:0] exp_awaddr,
                           input logic [1:0] bresp, input int max_stall, input int exp_lat);
    int st;
    cyc_cnt       = 0;
    write_address = addr;
    write_active  = 1'b1;
    step();
    write_active = 1'b0;
    check("wr_idle_low", write_idle, 1'b0);
    check("awvalid", m_axi.awvalid, 1'b1);
    check("awaddr", m_axi.awaddr, exp_awaddr);
    check("awlen", m_axi.awlen, 8'(BL - 1));
    check("awsize", m_axi.awsize, 3'b010);
    check("awburst", m_axi.awburst, 2'b01);
    check("w_before_aw", m_axi.wvalid, 1'b0);
    st = $urandom_range(0, max_stall);
    for (int s = 0; s < st; s++) begin
      step();
      check("awvalid_hold", m_axi.awvalid, 1'b1);
      check("w_before_aw", m_axi.wvalid, 1'b0);
    end
    m_axi.awready = 1'b1;
    step();
    m_axi.awready = 1'b0;
    check("awvalid_drop", m_axi.awvalid, 1'b0);
    for (int i = 0; i < BL; i++) begin
      check("wvalid", m_axi.wvalid, 1'b1);
      check("wdata", m_axi.wdata, model_buf[i]);
      check("wlast", m_axi.wlast, (i == BL - 1));
      check("wstrb", m_axi.wstrb, 4'hF);
      st = $urandom_range(0, max_stall);
      m_axi.wready = 1'b0;
      for (int s = 0; s < st; s++) begin
        step();
        check("wvalid_hold", m_axi.wvalid, 1'b1);
        check("wdata_hold", m_axi.wdata, model_buf[i]);
        check("wlast_hold", m_axi.wlast, (i == BL - 1));
      end
      m_axi.wready = 1'b1;
      step();
    end
    m_axi.wready = 1'b0;
    check("wvalid_done", m_axi.wvalid, 1'b0);
    check("bready", m_axi.bready, 1'b1);
    st = $urandom_range(0, max_stall);
    for (int s = 0; s < st; s++) begin
      step();
      check("bready_hold", m_axi.bready, 1'b1);
    end
    m_axi.bvalid = 1'b1;
    m_axi.bresp  = bresp;
    step();
    m_axi.bvalid = 1'b0;
    m_axi.bresp  = 2'b00;
    check("wr_idle_done", write_idle, 1'b1);
    check("bready_done", m_axi.bready, 1'b0);
    check("rw_resp_wr", rw_resp, {model_rd, bresp});
    if (exp_lat >= 0) check("wr_latency", cyc_cnt, exp_lat);
    model_wr = bresp;
    $display("write awaddr=0x%08h bresp=%02b cycles=%0d", exp_awaddr, bresp, cyc_cnt);
  endtask

  task automatic idle_quiet(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      check("no_aw_issued", m_axi.awvalid, 1'b0);
      check("wr_idle_quiet", write_idle, 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic [31:0] w;
    int          kind;
    int          e;

    vecs[0] = '{32'h0000_1000, 32'h0000_1000, 1'b0, 1'b0, -1, 2'b00, 15, 32'h0000_0000, 2'b00,
                1'b1, 32'h0000_2000, 32'h0000_2000, 2'b01};
    vecs[1] = '{32'h0000_3007, 32'h0000_3004, 1'b0, 1'b0,  3, 2'b10, 15, 32'h0000_0100, 2'b10,
                1'b1, 32'h0000_4002, 32'h0000_4000, 2'b00};
    vecs[2] = '{32'h0000_5040, 32'h0000_5040, 1'b0, 1'b0, -1, 2'b00, 10, 32'hA000_0000, 2'b10,
                1'b1, 32'h0000_6FC0, 32'h0000_6FC0, 2'b10};
    vecs[3] = '{32'h0000_7000, 32'h0000_7000, 1'b0, 1'b0,  0, 2'b11,  5, 32'h0000_0055, 2'b11,
                1'b1, 32'h0000_8004, 32'h0000_8004, 2'b11};
    vecs[4] = '{32'h0000_9000, 32'h0000_9000, 1'b0, 1'b1, -1, 2'b00, -1, 32'h1234_0000, 2'b10,
                1'b1, 32'h0000_A000, 32'h0000_A000, 2'b01};
    vecs[5] = '{32'h0000_B000, 32'h0000_B000, 1'b1, 1'b0, -1, 2'b00, 15, 32'h0BAD_0000, 2'b00,
                1'b0, 32'h0000_0000, 32'h0000_0000, 2'b00};

    axi_resetnn   = 1'b0;
    read_active   = 1'b0;
    read_address  = '0;
    write_active  = 1'b0;
    write_address = '0;
    m_axi.arready = 1'b0;
    m_axi.rdata   = '0;
    m_axi.rresp   = 2'b00;
    m_axi.rlast   = 1'b0;
    m_axi.rvalid  = 1'b0;
    m_axi.awready = 1'b0;
    m_axi.wready  = 1'b0;
    m_axi.bresp   = 2'b00;
    m_axi.bvalid  = 1'b0;
    model_rd      = 2'b00;
    model_wr      = 2'b00;

    repeat (3) step();
    check("rst_read_idle", read_idle, 1'b1);
    check("rst_write_idle", write_idle, 1'b1);
    check("rst_rw_resp", rw_resp, 4'h0);
    check("rst_arvalid", m_axi.arvalid, 1'b0);
    check("rst_rready", m_axi.rready, 1'b0);
    check("rst_awvalid", m_axi.awvalid, 1'b0);
    check("rst_wvalid", m_axi.wvalid, 1'b0);
    check("rst_bready", m_axi.bready, 1'b0);
    axi_resetnn = 1'b1;
    step();

    // Directed table, zero-wait slave so exact latencies are checked.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < BL; i++) begin
        beat_data[i] = vecs[v].data_base + 32'(i);
        beat_resp[i] = (i == vecs[v].err_beat) ? vecs[v].err_val : 2'b00;
        beat_last[i] = (i == vecs[v].last_beat);
      end
      run_read(vecs[v].rd_addr, vecs[v].exp_araddr, vecs[v].both, vecs[v].noise, 0,
               vecs[v].exp_rd, BL + 2);
      if (vecs[v].both || vecs[v].noise) idle_quiet(3);
      if (vecs[v].wr_en) begin
        step();
        run_write(vecs[v].wr_addr, vecs[v].exp_awaddr, vecs[v].bresp, 0, BL + 3);
      end
      step();
    end

    // Randomized copies with 0-5 cycle stalls on every channel.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < BL; i++) begin
        beat_data[i] = $urandom;
        beat_resp[i] = 2'b00;
        beat_last[i] = (i == BL - 1);
      end
      kind = $urandom_range(0, 3);
      if (kind == 1 || kind == 3) begin
        e = $urandom_range(0, BL - 1);
        beat_resp[e] = 2'($urandom_range(1, 3));
      end
      if (kind == 2 || kind == 3) begin
        e = $urandom_range(0, BL - 2);
        beat_last[e] = 1'b1;
      end
      a = $urandom;
      a[11:0] = 12'($urandom_range(0, 4096 - 4 * BL));
      w = $urandom;
      w[11:0] = 12'($urandom_range(0, 4096 - 4 * BL));
      run_read(a, a & 32'hFFFF_FFFC, 1'b0, 1'b0, 5, model_status(), -1);
      step();
      run_write(w, w & 32'hFFFF_FFFC, 2'($urandom_range(0, 3)), 5, -1);
      step();
    end

    // Mid-burst reset during beat 7 of a read; make rw_resp non-zero first.
    run_write(32'h0000_C000, 32'h0000_C000, 2'b11, 0, BL + 3);
    step();
    cyc_cnt      = 0;
    read_address = 32'h0000_1000;
    read_active  = 1'b1;
    step();
    read_active   = 1'b0;
    m_axi.arready = 1'b1;
    step();
    m_axi.arready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      m_axi.rvalid = 1'b1;
      m_axi.rdata  = 32'(i);
      m_axi.rresp  = 2'b00;
      m_axi.rlast  = 1'b0;
      step();
    end
    check("pre_rst_busy", read_idle, 1'b0);
    m_axi.rdata = 32'd7;
    axi_resetnn = 1'b0;
    step();
    axi_resetnn  = 1'b1;
    m_axi.rvalid = 1'b0;
    check("midrst_read_idle", read_idle, 1'b1);
    check("midrst_write_idle", write_idle, 1'b1);
    check("midrst_rready", m_axi.rready, 1'b0);
    check("midrst_arvalid", m_axi.arvalid, 1'b0);
    check("midrst_rw_resp", rw_resp, 4'h0);
    $display("reset during read beat 7, engine back to idle");
    model_rd = 2'b00;
    model_wr = 2'b00;
    step();

    // Engine must be fully usable again after the abandoned burst.
    for (int i = 0; i < BL; i++) begin
      beat_data[i] = 32'(i);
      beat_resp[i] = 2'b00;
      beat_last[i] = (i == BL - 1);
    end
    run_read(32'h0000_1000, 32'h0000_1000, 1'b0, 1'b0, 0, 2'b00, BL + 2);
    step();
    run_write(32'h0000_2000, 32'h0000_2000, 2'b01, 0, BL + 3);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
